hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_pkg.sv | 17 +
 rtl/forward_sel.sv | 23 ++
 rtl/hazard_unit.sv | 149 ++++++++++++++
 tb/tb_hazard_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: FSM states, forward selects,
// result-source and PC-source constants.
package hazard_pkg;

    typedef enum logic {
        RUN,
        MC_BUSY
    } hu_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [2:0] NEXT_PC     = 3'b000;

endpackage

// File: rtl/forward_sel.sv
// Picks the source of one Execute-stage ALU operand from the in-flight
// Memory and Writeback destinations; Memory is the newer value so it wins.
module forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for a five-stage pipeline: operand forwarding, load-use stall,
// branch redirect flush and a watchdog-guarded multi-cycle execute stall.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MC_MAX_CYCLES = 34
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic       RegWriteE,
    input  logic [1:0] ResultSrcE,
    input  logic [2:0] PCsrcE,
    input  logic       McStartE,
    input  logic       McDoneE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       McTimeout
);

    localparam logic [7:0] MC_LIMIT = 8'(MC_MAX_CYCLES);

    hu_state_e  state_q, state_d;
    logic [7:0] busy_cnt_q, busy_cnt_d;
    logic       timeout_q, timeout_d;
    logic [4:0] rd_m_q, rd_m_d;
    logic [4:0] rd_w_q, rd_w_d;
    logic       reg_write_m_q, reg_write_m_d;
    logic       reg_write_w_q, reg_write_w_d;

    logic       mc_stall;
    logic       load_use;
    logic       redirect;

    // Once the watchdog has fired, multi-cycle stalls stay disabled until reset.
    assign mc_stall = McStartE && !McDoneE && !timeout_q;
    assign redirect = (PCsrcE != NEXT_PC);
    assign load_use = RegWriteE && (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (mc_stall) begin
                    state_d    = MC_BUSY;
                    busy_cnt_d = 8'd0;
                end
            end
            MC_BUSY: begin
                if (McDoneE || !McStartE) begin
                    state_d = RUN;
                end else begin
                    busy_cnt_d = busy_cnt_q + 8'd1;
                    if (busy_cnt_d >= MC_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (mc_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
        end else if (redirect) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // A held Execute stage sends a bubble into Memory.
    always_comb begin
        rd_w_d        = rd_m_q;
        reg_write_w_d = reg_write_m_q;
        if (StallE) begin
            rd_m_d        = 5'd0;
            reg_write_m_d = 1'b0;
        end else begin
            rd_m_d        = RdE;
            reg_write_m_d = RegWriteE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            busy_cnt_q    <= 8'd0;
            timeout_q     <= 1'b0;
            rd_m_q        <= 5'd0;
            rd_w_q        <= 5'd0;
            reg_write_m_q <= 1'b0;
            reg_write_w_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_cnt_q    <= busy_cnt_d;
            timeout_q     <= timeout_d;
            rd_m_q        <= rd_m_d;
            rd_w_q        <= rd_w_d;
            reg_write_m_q <= reg_write_m_d;
            reg_write_w_q <= reg_write_w_d;
        end
    end

    assign McTimeout = timeout_q;

    forward_sel u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (rd_m_q),
        .reg_write_m (reg_write_m_q),
        .rd_w        (rd_w_q),
        .reg_write_w (reg_write_w_q),
        .fwd_sel     (ForwardAE)
    );

    forward_sel u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (rd_m_q),
        .reg_write_m (reg_write_m_q),
        .rd_w        (rd_w_q),
        .reg_write_w (reg_write_w_q),
        .fwd_sel     (ForwardBE)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit with a short watchdog limit.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic       RegWriteE;
    logic [1:0] ResultSrcE;
    logic [2:0] PCsrcE;
    logic       McStartE, McDoneE;
    logic       StallF, StallD, StallE, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       McTimeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_unit #(.MC_MAX_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .PCsrcE     (PCsrcE),
        .McStartE   (McStartE),
        .McDoneE    (McDoneE),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .McTimeout  (McTimeout)
    );

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_e(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic rw, input logic [1:0] rsrc);
        Rs1E       = rs1;
        Rs2E       = rs2;
        RdE        = rd;
        RegWriteE  = rw;
        ResultSrcE = rsrc;
    endtask

    task automatic apply_d(input logic [4:0] rs1, input logic [4:0] rs2);
        Rs1D = rs1;
        Rs2D = rs2;
    endtask

    task automatic check_stalls(input string tag, input logic sf, input logic sd, input logic se,
                                input logic fd, input logic fe);
        check_output({tag, "_StallF"}, {7'd0, StallF}, {7'd0, sf});
        check_output({tag, "_StallD"}, {7'd0, StallD}, {7'd0, sd});
        check_output({tag, "_StallE"}, {7'd0, StallE}, {7'd0, se});
        check_output({tag, "_FlushD"}, {7'd0, FlushD}, {7'd0, fd});
        check_output({tag, "_FlushE"}, {7'd0, FlushE}, {7'd0, fe});
    endtask

    initial begin
        rst_n    = 1'b0;
        apply_e(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        apply_d(5'd0, 5'd0);
        PCsrcE   = 3'b000;
        McStartE = 1'b0;
        McDoneE  = 1'b0;

        // Reset state, then combinational outputs following inputs during reset
        #1;
        check_output("rst_fwdA", {6'd0, ForwardAE}, 8'h00);
        check_output("rst_fwdB", {6'd0, ForwardBE}, 8'h00);
        check_output("rst_timeout", {7'd0, McTimeout}, 8'h00);
        check_stalls("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_e(5'd3, 5'd0, 5'd3, 1'b1, 2'b01);
        apply_d(5'd3, 5'd0);
        settle();
        check_stalls("rst_lu", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output("rst_lu_fwdA", {6'd0, ForwardAE}, 8'h00);
        apply_e(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        apply_d(5'd0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Forwarding: add x5,x1,x2 ; add x6,x5,x1 ; add x7,x6,x5 ; ...
        apply_e(5'd1, 5'd2, 5'd5, 1'b1, 2'b00);
        settle();
        check_output("A_fwdA", {6'd0, ForwardAE}, 8'h00);
        tick();
        apply_e(5'd5, 5'd1, 5'd6, 1'b1, 2'b00);
        settle();
        check_output("B_fwdA_mem", {6'd0, ForwardAE}, 8'h02);
        check_output("B_fwdB_rf", {6'd0, ForwardBE}, 8'h00);
        tick();
        apply_e(5'd6, 5'd5, 5'd7, 1'b1, 2'b00);
        settle();
        check_output("C_fwdA_mem", {6'd0, ForwardAE}, 8'h02);
        check_output("C_fwdB_wb", {6'd0, ForwardBE}, 8'h01);
        tick();
        apply_e(5'd6, 5'd7, 5'd0, 1'b0, 2'b00);
        settle();
        check_output("D_fwdA_wb", {6'd0, ForwardAE}, 8'h01);
        check_output("D_fwdB_mem", {6'd0, ForwardBE}, 8'h02);
        tick();
        apply_e(5'd0, 5'd0, 5'd8, 1'b1, 2'b00);
        settle();
        check_output("E_fwdA_x0", {6'd0, ForwardAE}, 8'h00);
        tick();
        apply_e(5'd8, 5'd7, 5'd8, 1'b1, 2'b00);
        settle();
        check_output("F_fwdA_mem", {6'd0, ForwardAE}, 8'h02);
        check_output("F_fwdB_rf", {6'd0, ForwardBE}, 8'h00);
        tick();
        apply_e(5'd8, 5'd0, 5'd0, 1'b1, 2'b00);
        settle();
        check_output("G_fwdA_prio", {6'd0, ForwardAE}, 8'h02);
        tick();
        apply_e(5'd0, 5'd8, 5'd0, 1'b0, 2'b00);
        settle();
        check_output("H_fwdA_x0", {6'd0, ForwardAE}, 8'h00);
        check_output("H_fwdB_wb", {6'd0, ForwardBE}, 8'h01);
        tick();

        // Load-use: lw x7 in Execute, consumer reads x7 in Decode
        apply_e(5'd0, 5'd0, 5'd7, 1'b1, 2'b01);
        apply_d(5'd0, 5'd7);
        settle();
        check_stalls("L1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        apply_e(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        settle();
        check_stalls("L2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        apply_e(5'd0, 5'd7, 5'd0, 1'b0, 2'b00);
        apply_d(5'd0, 5'd0);
        settle();
        check_output("L3_fwdB_wb", {6'd0, ForwardBE}, 8'h01);
        tick();

        // Redirect overrides load-use
        apply_e(5'd0, 5'd0, 5'd7, 1'b1, 2'b01);
        apply_d(5'd0, 5'd7);
        PCsrcE = 3'b001;
        settle();
        check_stalls("RD", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        PCsrcE = 3'b000;
        apply_e(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        apply_d(5'd0, 5'd0);
        tick();
        tick();

        // Multi-cycle op finishing on its 5th cycle, with load-use inputs present
        McStartE = 1'b1;
        apply_e(5'd9, 5'd0, 5'd9, 1'b1, 2'b01);
        apply_d(5'd9, 5'd0);
        for (int i = 0; i < 4; i++) begin
            settle();
            check_stalls($sformatf("MC%0d", i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            check_output($sformatf("MC%0d_fwdA", i), {6'd0, ForwardAE}, 8'h00);
            tick();
        end
        McDoneE = 1'b1;
        settle();
        check_stalls("MC4_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_output("MC4_timeout", {7'd0, McTimeout}, 8'h00);
        tick();
        McStartE = 1'b0;
        McDoneE  = 1'b0;
        apply_e(5'd9, 5'd0, 5'd0, 1'b0, 2'b00);
        apply_d(5'd0, 5'd0);
        settle();
        check_output("MC5_fwdA_mem", {6'd0, ForwardAE}, 8'h02);
        check_output("MC5_StallE", {7'd0, StallE}, 8'h00);
        tick();

        // Watchdog: McDoneE never arrives, limit of 4 busy cycles
        apply_e(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
        McStartE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            check_output($sformatf("T%0d_StallE", i), {7'd0, StallE}, 8'h01);
            check_output($sformatf("T%0d_timeout", i), {7'd0, McTimeout}, 8'h00);
            tick();
        end
        for (int i = 5; i < 7; i++) begin
            settle();
            check_output($sformatf("T%0d_timeout", i), {7'd0, McTimeout}, 8'h01);
            check_stalls($sformatf("T%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        McStartE = 1'b0;
        #2;
        rst_n = 1'b0;
        settle();
        check_output("T_rst_timeout", {7'd0, McTimeout}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset pulsed in the middle of a busy multi-cycle op
        apply_e(5'd0, 5'd0, 5'd10, 1'b1, 2'b00);
        tick();
        McStartE = 1'b1;
        apply_e(5'd10, 5'd0, 5'd0, 1'b0, 2'b00);
        settle();
        check_output("R0_fwdA_mem", {6'd0, ForwardAE}, 8'h02);
        check_output("R0_StallE", {7'd0, StallE}, 8'h01);
        tick();
        settle();
        check_output("R1_fwdA_wb", {6'd0, ForwardAE}, 8'h01);
        check_output("R1_StallE", {7'd0, StallE}, 8'h01);
        rst_n = 1'b0;
        settle();
        check_output("R1_rst_fwdA", {6'd0, ForwardAE}, 8'h00);
        check_output("R1_rst_StallE", {7'd0, StallE}, 8'h01);
        McStartE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        settle();
        check_stalls("R2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_output("R2_fwdA", {6'd0, ForwardAE}, 8'h00);
        check_output("R2_timeout", {7'd0, McTimeout}, 8'h00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
